// File: rtl/simdive_pkg.sv
// Shared constants, stage bundle and helpers for the SIMDive
// log-domain back end.
package simdive_pkg;

  localparam int W       = 16;
  localparam int KW      = 6;
  localparam int FW      = 15;
  localparam int LANE_W  = W / 2;
  localparam int SIMD_FW = W / 2 - 1;
  localparam int MW      = FW + 1;

  localparam logic MODE_SIMD = 1'b0;
  localparam logic MODE_FULL = 1'b1;
  localparam logic FUNC_MUL  = 1'b0;
  localparam logic FUNC_DIV  = 1'b1;

  typedef struct packed {
    logic [1:0][MW-1:0] m;
    logic [1:0][KW-1:0] k;
    logic               func;
    logic               mode;
    logic [1:0]         zero;
    logic [1:0]         dz;
  } s1_t;

  // SIMD lanes carry only the top SIMD_FW fraction bits
  function automatic logic [MW-1:0] mant(
    input logic [FW-1:0] f,
    input logic          mode
  );
    logic [FW-1:0] msk;
    msk = {FW{1'b1}};
    if (mode == MODE_SIMD)
      msk = {{SIMD_FW{1'b1}}, {(FW-SIMD_FW){1'b0}}};
    return {1'b1, f & msk};
  endfunction

endpackage

// File: rtl/simdive_antilog_lane.sv
// One Mitchell antilog lane: mantissa shift by the characteristic,
// field-width saturation and zero / divide-by-zero handling.
module simdive_antilog_lane
  import simdive_pkg::*;
#(
  parameter int OW = 2 * W
) (
  input  logic                 wide_i,
  input  logic                 func_i,
  input  logic                 zero_i,
  input  logic                 dz_i,
  input  logic [MW-1:0]        m_i,
  input  logic signed [KW-1:0] k_i,
  output logic [OW-1:0]        res_o,
  output logic                 dz_o
);

  localparam int KMAX = 2 ** (KW - 1) - 1;
  localparam int SW   = MW + KMAX;
  localparam int FBW  = $clog2(OW + 1);

  logic [FBW-1:0] pbits;
  logic [FBW-1:0] qbits;
  logic [SW-1:0]  pmask;
  logic [SW-1:0]  qmask;
  logic [SW-1:0]  fmask;
  logic [SW-1:0]  sh;
  logic [SW-1:0]  val;
  logic           over;

  // product field is OW (or OW/2 when narrow); quotient is half that
  always_comb begin
    pbits = wide_i ? FBW'(OW) : FBW'(OW / 2);
    qbits = pbits >> 1;
    pmask = (SW'(1) << pbits) - SW'(1);
    qmask = (SW'(1) << qbits) - SW'(1);
    fmask = func_i ? qmask : pmask;
  end

  // negative k is handled below, so only the magnitude bits shift
  always_comb begin
    sh   = SW'(m_i) << k_i[KW-2:0];
    val  = sh >> FW;
    over = |(val & ~fmask);
  end

  always_comb begin
    res_o = '0;
    dz_o  = 1'b0;
    if (func_i && dz_i) begin
      res_o = qmask[OW-1:0];
      dz_o  = 1'b1;
    end else if (zero_i || k_i[KW-1]) begin
      res_o = '0;
    end else if (over) begin
      res_o = fmask[OW-1:0];
    end else begin
      res_o = val[OW-1:0];
    end
  end

endmodule

// File: rtl/simdive_antilog_unit.sv
// SIMDive antilog back end: two-stage pipeline converting combined
// log words to binary results, one full lane or two SIMD lanes.
module simdive_antilog_unit
  import simdive_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic              func,
  input  logic [2*KW-1:0]   k_in,
  input  logic [2*FW-1:0]   f_in,
  input  logic [1:0]        zero_in,
  input  logic [1:0]        dz_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*W-1:0]    result,
  output logic [1:0]        dz_out
);

  s1_t              s1_q;
  s1_t              s1_d;
  logic             s1_vld_q;
  logic             s2_vld_q;
  logic [2*W-1:0]   res_q;
  logic [2*W-1:0]   res_d;
  logic [1:0]       dz_q;
  logic [1:0]       dz_d;
  logic             stall;

  logic [2*W-1:0]   r0;
  logic [W-1:0]     r1;
  logic             d0;
  logic             d1;

  // a held output freezes every stage
  assign stall    = s2_vld_q & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    s1_d      = '0;
    s1_d.m[0] = mant(f_in[FW-1:0], mode);
    s1_d.m[1] = mant(f_in[2*FW-1:FW], mode);
    s1_d.k[0] = k_in[KW-1:0];
    s1_d.k[1] = k_in[2*KW-1:KW];
    s1_d.func = func;
    s1_d.mode = mode;
    s1_d.zero = zero_in;
    s1_d.dz   = dz_in;
  end

  simdive_antilog_lane #(
    .OW (2 * W)
  ) u_lane0 (
    .wide_i (s1_q.mode == MODE_FULL),
    .func_i (s1_q.func),
    .zero_i (s1_q.zero[0]),
    .dz_i   (s1_q.dz[0]),
    .m_i    (s1_q.m[0]),
    .k_i    ($signed(s1_q.k[0])),
    .res_o  (r0),
    .dz_o   (d0)
  );

  simdive_antilog_lane #(
    .OW (W)
  ) u_lane1 (
    .wide_i (1'b1),
    .func_i (s1_q.func),
    .zero_i (s1_q.zero[1]),
    .dz_i   (s1_q.dz[1]),
    .m_i    (s1_q.m[1]),
    .k_i    ($signed(s1_q.k[1])),
    .res_o  (r1),
    .dz_o   (d1)
  );

  // full mode ignores lane 1 entirely
  always_comb begin
    res_d = r0;
    dz_d  = {1'b0, d0};
    if (s1_q.mode == MODE_SIMD) begin
      res_d = {r1, r0[W-1:0]};
      dz_d  = {d1, d0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      res_q    <= '0;
      dz_q     <= '0;
    end else if (!stall) begin
      s1_vld_q <= in_valid;
      s2_vld_q <= s1_vld_q;
      if (in_valid)
        s1_q <= s1_d;
      if (s1_vld_q) begin
        res_q <= res_d;
        dz_q  <= dz_d;
      end
    end
  end

  assign out_valid = s2_vld_q;
  assign result    = res_q;
  assign dz_out    = dz_q;

endmodule

// File: tb/tb_simdive_antilog_unit.sv
// Scoreboard bench for simdive_antilog_unit with a behavioural
// antilog model, random traffic and random backpressure.
module tb_simdive_antilog_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic        func;
  logic [11:0] k_in;
  logic [29:0] f_in;
  logic [1:0]  zero_in;
  logic [1:0]  dz_in;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [1:0]  dz_out;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   rdy_rand = 1'b0;
  int   hold_lo = -10;
  int   hold_hi = -10;

  bit          held = 1'b0;
  logic [31:0] hres;
  logic [1:0]  hdz;

  always #5 clk = ~clk;

  simdive_antilog_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .func      (func),
    .k_in      (k_in),
    .f_in      (f_in),
    .zero_in   (zero_in),
    .dz_in     (dz_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .dz_out    (dz_out)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // value = 1.f * 2^k, truncated, clipped to the field width
  function automatic void lane_model(
    input int k, input int f, input bit simd, input bit fn,
    input bit z, input bit d, input int pb, input int qb,
    output longint r, output bit dzo);
    longint mv;
    longint v;
    longint lim;
    dzo = 1'b0;
    mv = 64'd32768 + longint'(simd ? (f & 32'h7F00) : f);
    if (fn && d) begin
      r = (64'd1 << qb) - 1;
      dzo = 1'b1;
    end else if (z || k < 0) begin
      r = 0;
    end else begin
      v = mv * (64'd1 << k) / 64'd32768;
      lim = 64'd1 << (fn ? qb : pb);
      r = (v >= lim) ? lim - 1 : v;
    end
  endfunction

  task automatic send(input bit md, input bit fn,
                      input int k0, input int f0,
                      input int k1, input int f1,
                      input bit [1:0] z, input bit [1:0] d,
                      input bit cst, input logic [31:0] cr,
                      input logic [1:0] cd);
    exp_t   e;
    longint r0;
    longint r1;
    bit     d0;
    bit     d1;
    bit     ok;
    if (md) begin
      lane_model(k0, f0, 1'b0, fn, z[0], d[0], 32, 16, r0, d0);
      e.res = r0[31:0];
      e.dz  = {1'b0, d0};
    end else begin
      lane_model(k0, f0, 1'b1, fn, z[0], d[0], 16, 8, r0, d0);
      lane_model(k1, f1, 1'b1, fn, z[1], d[1], 16, 8, r1, d1);
      e.res = {r1[15:0], r0[15:0]};
      e.dz  = {d1, d0};
    end
    if (cst) begin
      e.res = cr;
      e.dz  = cd;
    end
    mode     = md;
    func     = fn;
    k_in     = {6'(k1), 6'(k0)};
    f_in     = {15'(f1), 15'(f0)};
    zero_in  = z;
    dz_in    = d;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout act=no_accept exp=accept");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rdy_rand)
      out_ready = ($urandom % 4) != 0;
    else
      out_ready = !(cyc >= hold_lo && cyc <= hold_hi);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      exp_t e;
      if (held)
        chk("hold", {31'd0, out_valid, dz_out, result},
            {31'd0, 1'b1, hdz, hres});
      chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious act=%h exp=none", result);
        end else begin
          e = sb.pop_front();
          chk("result", {30'd0, dz_out, result}, {30'd0, e.dz, e.res});
        end
      end
      held = out_valid && !out_ready;
      hres = result;
      hdz  = dz_out;
    end
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    mode     = 1'b0;
    func     = 1'b0;
    k_in     = '0;
    f_in     = '0;
    zero_in  = '0;
    dz_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", {29'd0, out_valid, dz_out, result}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rdy_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    send(1, 0, 3, 'h6000, 0, 0, 2'b00, 2'b00, 1, 32'd14, 2'b00);
    send(0, 1, 4, 'h4000, -1, 0, 2'b00, 2'b00, 1, 32'h18, 2'b00);
    send(0, 1, 0, 0, 5, 0, 2'b10, 2'b10, 1, 32'h00FF0001, 2'b10);
    send(1, 0, 30, 'h7FFF, 0, 0, 2'b00, 2'b00, 1, 32'h7FFF8000, 2'b00);
    send(1, 0, -3, 'h1234, 0, 0, 2'b00, 2'b00, 1, 32'd0, 2'b00);
    send(1, 1, 20, 'h0000, 0, 0, 2'b00, 2'b00, 1, 32'h0000FFFF, 2'b00);
    idle(4);

    hold_lo = cyc + 3;
    hold_hi = cyc + 5;
    for (int i = 0; i < 4; i++)
      send(0, 0, i + 2, $urandom_range(0, 32767), 7 - i,
           $urandom_range(0, 32767), 2'b00, 2'b00, 0, '0, '0);
    idle(8);

    send(1, 0, 5, 'h1000, 0, 0, 2'b00, 2'b00, 0, '0, '0);
    send(0, 0, 6, 'h2000, 3, 0, 2'b00, 2'b00, 0, '0, '0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst", {29'd0, out_valid, dz_out, result}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(1, 0, 9, 'h0ABC, 0, 0, 2'b00, 2'b00, 0, '0, '0);
    in_valid = 1'b0;
    chk("lat1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat2", 64'(out_valid), 64'd1);
    idle(3);

    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send($urandom_range(0, 1), $urandom_range(0, 1),
           int'($urandom_range(0, 63)) - 32, $urandom_range(0, 32767),
           int'($urandom_range(0, 63)) - 32, $urandom_range(0, 32767),
           2'($urandom_range(0, 7) == 0 ? $urandom_range(0, 3) : 0),
           2'($urandom_range(0, 7) == 0 ? $urandom_range(0, 3) : 0),
           0, '0, '0);
      n = $urandom_range(0, 3);
      if (n == 0)
        idle(1);
    end
    in_valid = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain act=%0d exp=0", sb.size());
    end
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
